// File: rtl/multicycle_ctrl_fsm.sv
// ============================================================================
// Module      : multicycle_ctrl_fsm
// Description : Multicycle CPU controller. Holds the state register, computes
//               the next state and decodes Moore/Mealy datapath controls.
//               Memory accesses use a mem_req/mem_ready handshake with a
//               timeout. HALT can be resumed; ERROR is sticky.
// Ports       : clk, rst (async, active-high)
//               op_code, lt_flag, mem_ready, resume       - control inputs
//               alu_op, alu_src_a_mux_sel, alu_src_b_mux_sel,
//               load_instr, hold_decode, instr_or_data_mux_sel,
//               mem_req, mem_write_en, reg_write_en,
//               reg_write_mux_sel, halt_clk, error         - datapath controls
//               retired_cnt, stall_cnt                     - only with CTRL_PERF_CNT_EN
// Config      : `define CTRL_PERF_CNT_EN adds the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl_fsm #(
  parameter int OPCODE_W    = 3,
  parameter int ALU_OP_W    = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] op_code,
  input  logic                lt_flag,
  input  logic                mem_ready,
  input  logic                resume,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_a_mux_sel,
  output logic [1:0]          alu_src_b_mux_sel,
  output logic                load_instr,
  output logic                hold_decode,
  output logic                instr_or_data_mux_sel,
  output logic                mem_req,
  output logic                mem_write_en,
  output logic                reg_write_en,
  output logic                reg_write_mux_sel,
  output logic                halt_clk,
  output logic                error
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]         retired_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] OP_HALT  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_CMP   = 3'b110;
  localparam logic [2:0] OP_BLT   = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_ADDR   = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WB = 4'd5,
    S_MEM_WR = 4'd6,
    S_EXEC   = 4'd7,
    S_ALU_WB = 4'd8,
    S_CMP    = 4'd9,
    S_BLT    = 4'd10,
    S_HALT   = 4'd11,
    S_ERROR  = 4'd12
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             wait_inc;
  logic [2:0]       opc;
  logic             op_hi_bad;

  assign opc = op_code[2:0];

  // Any set bit above the 3-bit opcode field makes the instruction illegal.
  generate
    if (OPCODE_W > 3) begin : g_op_hi
      assign op_hi_bad = |op_code[OPCODE_W-1:3];
    end else begin : g_op_no_hi
      assign op_hi_bad = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    wait_cnt_d            = '0;
    wait_inc              = 1'b0;
    alu_op                = '0;
    alu_src_a_mux_sel     = 1'b0;
    alu_src_b_mux_sel     = 2'b00;
    load_instr            = 1'b0;
    instr_or_data_mux_sel = 1'b0;
    mem_req               = 1'b0;
    mem_write_en          = 1'b0;
    reg_write_en          = 1'b0;
    reg_write_mux_sel     = 1'b0;
    halt_clk              = 1'b0;
    error                 = 1'b0;
    hold_decode           = (state_q != S_IDLE) && (state_q != S_FETCH);

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req           = 1'b1;
        alu_src_b_mux_sel = 2'b11;
        load_instr        = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (op_hi_bad) begin
          state_d = S_ERROR;
        end else begin
          case (opc)
            OP_HALT:                  state_d = S_HALT;
            OP_ADD, OP_SUB, OP_AND:   state_d = S_EXEC;
            OP_LOAD, OP_STORE:        state_d = S_ADDR;
            OP_CMP:                   state_d = S_CMP;
            OP_BLT:                   state_d = S_BLT;
            default:                  state_d = S_ERROR;
          endcase
        end
      end
      S_ADDR: begin
        alu_src_a_mux_sel = 1'b1;
        alu_src_b_mux_sel = 2'b10;
        state_d           = (opc == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req               = 1'b1;
        instr_or_data_mux_sel = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_en = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req               = 1'b1;
        mem_write_en          = 1'b1;
        instr_or_data_mux_sel = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a_mux_sel = 1'b1;
        alu_src_b_mux_sel = 2'b01;
        case (opc)
          OP_SUB:  alu_op = ALU_OP_W'(2'b01);
          OP_AND:  alu_op = ALU_OP_W'(2'b10);
          default: alu_op = ALU_OP_W'(2'b00);
        endcase
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_en      = 1'b1;
        reg_write_mux_sel = 1'b1;
        state_d           = S_FETCH;
      end
      S_CMP: begin
        alu_op            = ALU_OP_W'(2'b11);
        alu_src_a_mux_sel = 1'b1;
        alu_src_b_mux_sel = 2'b01;
        state_d           = S_FETCH;
      end
      S_BLT: begin
        alu_src_b_mux_sel = 2'b10;
        load_instr        = lt_flag;
        state_d           = S_FETCH;
      end
      S_HALT: begin
        halt_clk = 1'b1;
        if (resume) state_d = S_FETCH;
      end
      S_ERROR: begin
        halt_clk = 1'b1;
        error    = 1'b1;
      end
      default: state_d = S_ERROR;
    endcase

    // Memory wait tracking. A completing mem_ready always takes priority
    // over the timeout, even on the limit cycle.
    if (((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR)) && !mem_ready) begin
      if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
        state_d = S_ERROR;
      end else begin
        wait_inc   = 1'b1;
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_q;
  logic [31:0] stall_q;
  logic        retire_evt;

  // An instruction retires on any return to FETCH except the initial entry
  // from IDLE and a HALT resume.
  assign retire_evt = (state_d == S_FETCH) && (state_q != S_FETCH) &&
                      (state_q != S_IDLE) && (state_q != S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (retire_evt) retired_q <= retired_q + 32'd1;
      if (wait_inc)   stall_q   <= stall_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
// ============================================================================
// Module      : tb_multicycle_ctrl_fsm
// Description : Directed self-checking bench for multicycle_ctrl_fsm. All
//               outputs are packed into one vector and compared against
//               hand-computed per-state constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl_fsm;

  // Output vector layout:
  // {alu_op[1:0], src_a, src_b[1:0], load_instr, hold_decode, instr_or_data,
  //  mem_req, mem_write_en, reg_write_en, reg_write_mux, halt_clk, error}
  localparam logic [13:0] E_IDLE      = 14'b00_0_00_0_0_0_0_0_0_0_0_0;
  localparam logic [13:0] E_FETCH     = 14'b00_0_11_0_0_0_1_0_0_0_0_0;
  localparam logic [13:0] E_FETCH_RDY = 14'b00_0_11_1_0_0_1_0_0_0_0_0;
  localparam logic [13:0] E_DECODE    = 14'b00_0_00_0_1_0_0_0_0_0_0_0;
  localparam logic [13:0] E_ADDR      = 14'b00_1_10_0_1_0_0_0_0_0_0_0;
  localparam logic [13:0] E_MEMRD     = 14'b00_0_00_0_1_1_1_0_0_0_0_0;
  localparam logic [13:0] E_MEMWB     = 14'b00_0_00_0_1_0_0_0_1_0_0_0;
  localparam logic [13:0] E_MEMWR     = 14'b00_0_00_0_1_1_1_1_0_0_0_0;
  localparam logic [13:0] E_EXEC_ADD  = 14'b00_1_01_0_1_0_0_0_0_0_0_0;
  localparam logic [13:0] E_EXEC_SUB  = 14'b01_1_01_0_1_0_0_0_0_0_0_0;
  localparam logic [13:0] E_ALUWB     = 14'b00_0_00_0_1_0_0_0_1_1_0_0;
  localparam logic [13:0] E_CMP       = 14'b11_1_01_0_1_0_0_0_0_0_0_0;
  localparam logic [13:0] E_BLT0      = 14'b00_0_10_0_1_0_0_0_0_0_0_0;
  localparam logic [13:0] E_BLT1      = 14'b00_0_10_1_1_0_0_0_0_0_0_0;
  localparam logic [13:0] E_HALT      = 14'b00_0_00_0_1_0_0_0_0_0_1_0;
  localparam logic [13:0] E_ERR       = 14'b00_0_00_0_1_0_0_0_0_0_1_1;

  logic        clk;
  logic        rst;
  logic [3:0]  op_code;
  logic        lt_flag;
  logic        mem_ready;
  logic        resume;
  logic [1:0]  alu_op;
  logic        alu_src_a_mux_sel;
  logic [1:0]  alu_src_b_mux_sel;
  logic        load_instr;
  logic        hold_decode;
  logic        instr_or_data_mux_sel;
  logic        mem_req;
  logic        mem_write_en;
  logic        reg_write_en;
  logic        reg_write_mux_sel;
  logic        halt_clk;
  logic        error;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;
`endif
  logic [13:0] outs;
  logic [13:0] exp_v;

  int total = 0;
  int bad   = 0;

  assign outs = {alu_op, alu_src_a_mux_sel, alu_src_b_mux_sel, load_instr, hold_decode,
                 instr_or_data_mux_sel, mem_req, mem_write_en, reg_write_en,
                 reg_write_mux_sel, halt_clk, error};

  multicycle_ctrl_fsm #(
    .OPCODE_W   (4),
    .ALU_OP_W   (2),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .op_code              (op_code),
    .lt_flag              (lt_flag),
    .mem_ready            (mem_ready),
    .resume               (resume),
    .alu_op               (alu_op),
    .alu_src_a_mux_sel    (alu_src_a_mux_sel),
    .alu_src_b_mux_sel    (alu_src_b_mux_sel),
    .load_instr           (load_instr),
    .hold_decode          (hold_decode),
    .instr_or_data_mux_sel(instr_or_data_mux_sel),
    .mem_req              (mem_req),
    .mem_write_en         (mem_write_en),
    .reg_write_en         (reg_write_en),
    .reg_write_mux_sel    (reg_write_mux_sel),
    .halt_clk             (halt_clk),
    .error                (error)
`ifdef CTRL_PERF_CNT_EN
    ,
    .retired_cnt          (retired_cnt),
    .stall_cnt            (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired before summary");
    $fatal(1);
  end

  // Advance one clock; inputs and checks happen 2 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_code = 4'd0; lt_flag = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    repeat (3) tick();
    if (outs !== E_IDLE) begin $display("FAIL reset_idle: got=%b exp=%b", outs, E_IDLE); bad++; end total++;
`ifdef CTRL_PERF_CNT_EN
    if (retired_cnt !== 32'd0) begin $display("FAIL reset_retired: got=%0d exp=0", retired_cnt); bad++; end total++;
    if (stall_cnt !== 32'd0) begin $display("FAIL reset_stall: got=%0d exp=0", stall_cnt); bad++; end total++;
`endif
    rst = 1'b0;
    #1;
    if (outs !== E_IDLE) begin $display("FAIL idle_after_release: got=%b exp=%b", outs, E_IDLE); bad++; end total++;
    tick();
    if (outs !== E_FETCH) begin $display("FAIL reset_fetch: got=%b exp=%b", outs, E_FETCH); bad++; end total++;
  endtask

  task automatic test_alu_ops();
    for (int k = 0; k < 2; k++) begin
      op_code = (k == 0) ? 4'd1 : 4'd2;
      mem_ready = 1'b1;
      #1;
      if (outs !== E_FETCH_RDY) begin $display("FAIL alu_fetch k=%0d: got=%b exp=%b", k, outs, E_FETCH_RDY); bad++; end total++;
      tick();
      if (outs !== E_DECODE) begin $display("FAIL alu_decode k=%0d: got=%b exp=%b", k, outs, E_DECODE); bad++; end total++;
      tick();
      exp_v = (k == 0) ? E_EXEC_ADD : E_EXEC_SUB;
      if (outs !== exp_v) begin $display("FAIL alu_exec k=%0d: got=%b exp=%b", k, outs, exp_v); bad++; end total++;
      tick();
      if (outs !== E_ALUWB) begin $display("FAIL alu_wb k=%0d: got=%b exp=%b", k, outs, E_ALUWB); bad++; end total++;
      tick();
      if (outs !== E_FETCH_RDY) begin $display("FAIL alu_return k=%0d: got=%b exp=%b", k, outs, E_FETCH_RDY); bad++; end total++;
    end
  endtask

  task automatic test_load_stall();
    op_code = 4'd4; mem_ready = 1'b1;
    tick();
    if (outs !== E_DECODE) begin $display("FAIL load_decode: got=%b exp=%b", outs, E_DECODE); bad++; end total++;
    tick();
    if (outs !== E_ADDR) begin $display("FAIL load_addr: got=%b exp=%b", outs, E_ADDR); bad++; end total++;
    tick();
    mem_ready = 1'b0;
    #1;
    if (outs !== E_MEMRD) begin $display("FAIL load_memrd_1: got=%b exp=%b", outs, E_MEMRD); bad++; end total++;
    for (int i = 2; i <= 3; i++) begin
      tick();
      if (outs !== E_MEMRD) begin $display("FAIL load_memrd_%0d: got=%b exp=%b", i, outs, E_MEMRD); bad++; end total++;
    end
    tick();
    mem_ready = 1'b1;
    #1;
    if (outs !== E_MEMRD) begin $display("FAIL load_memrd_4: got=%b exp=%b", outs, E_MEMRD); bad++; end total++;
    tick();
    if (outs !== E_MEMWB) begin $display("FAIL load_memwb: got=%b exp=%b", outs, E_MEMWB); bad++; end total++;
    tick();
    if (outs !== E_FETCH_RDY) begin $display("FAIL load_return: got=%b exp=%b", outs, E_FETCH_RDY); bad++; end total++;
`ifdef CTRL_PERF_CNT_EN
    if (retired_cnt !== 32'd3) begin $display("FAIL load_retired: got=%0d exp=3", retired_cnt); bad++; end total++;
    if (stall_cnt !== 32'd3) begin $display("FAIL load_stall: got=%0d exp=3", stall_cnt); bad++; end total++;
`endif
  endtask

  task automatic test_store();
    op_code = 4'd5;
    tick(); tick(); tick();
    if (outs !== E_MEMWR) begin $display("FAIL store_memwr: got=%b exp=%b", outs, E_MEMWR); bad++; end total++;
    tick();
    if (outs !== E_FETCH_RDY) begin $display("FAIL store_return: got=%b exp=%b", outs, E_FETCH_RDY); bad++; end total++;
  endtask

  task automatic test_cmp();
    op_code = 4'd6;
    tick(); tick();
    if (outs !== E_CMP) begin $display("FAIL cmp_state: got=%b exp=%b", outs, E_CMP); bad++; end total++;
    tick();
    if (outs !== E_FETCH_RDY) begin $display("FAIL cmp_return: got=%b exp=%b", outs, E_FETCH_RDY); bad++; end total++;
  endtask

  task automatic test_blt();
    for (int k = 0; k < 2; k++) begin
      op_code = 4'd7;
      lt_flag = (k == 0);
      tick(); tick();
      exp_v = (k == 0) ? E_BLT1 : E_BLT0;
      if (outs !== exp_v) begin $display("FAIL blt_state lt=%0d: got=%b exp=%b", lt_flag, outs, exp_v); bad++; end total++;
      tick();
      if (outs !== E_FETCH_RDY) begin $display("FAIL blt_return lt=%0d: got=%b exp=%b", lt_flag, outs, E_FETCH_RDY); bad++; end total++;
    end
    lt_flag = 1'b0;
  endtask

  task automatic test_halt();
    op_code = 4'd0; resume = 1'b0;
    tick(); tick();
    if (outs !== E_HALT) begin $display("FAIL halt_enter: got=%b exp=%b", outs, E_HALT); bad++; end total++;
    tick();
    if (outs !== E_HALT) begin $display("FAIL halt_hold: got=%b exp=%b", outs, E_HALT); bad++; end total++;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    #1;
    if (outs !== E_FETCH_RDY) begin $display("FAIL halt_resume: got=%b exp=%b", outs, E_FETCH_RDY); bad++; end total++;
`ifdef CTRL_PERF_CNT_EN
    if (retired_cnt !== 32'd7) begin $display("FAIL halt_retired: got=%0d exp=7", retired_cnt); bad++; end total++;
`endif
  endtask

  task automatic test_rst_mid_access();
    op_code = 4'd5; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    if (outs !== E_MEMWR) begin $display("FAIL rst_pre_memwr: got=%b exp=%b", outs, E_MEMWR); bad++; end total++;
    rst = 1'b1;
    #1;
    if (outs !== E_IDLE) begin $display("FAIL rst_mid_memwr: got=%b exp=%b", outs, E_IDLE); bad++; end total++;
    tick();
    rst = 1'b0;
`ifdef CTRL_PERF_CNT_EN
    #1;
    if (retired_cnt !== 32'd0) begin $display("FAIL rst_retired: got=%0d exp=0", retired_cnt); bad++; end total++;
`endif
    tick();
    if (outs !== E_FETCH) begin $display("FAIL rst_refetch: got=%b exp=%b", outs, E_FETCH); bad++; end total++;
  endtask

  task automatic test_timeout_boundary();
    op_code = 4'd1; mem_ready = 1'b0;
    repeat (15) tick();
    if (outs !== E_FETCH) begin $display("FAIL fetch_at_limit: got=%b exp=%b", outs, E_FETCH); bad++; end total++;
    mem_ready = 1'b1;
    #1;
    if (outs !== E_FETCH_RDY) begin $display("FAIL fetch_ready_limit: got=%b exp=%b", outs, E_FETCH_RDY); bad++; end total++;
    tick();
    if (outs !== E_DECODE) begin $display("FAIL ready_wins_at_limit: got=%b exp=%b", outs, E_DECODE); bad++; end total++;
`ifdef CTRL_PERF_CNT_EN
    if (stall_cnt !== 32'd15) begin $display("FAIL limit_stall: got=%0d exp=15", stall_cnt); bad++; end total++;
`endif
    tick(); tick(); tick();
    if (outs !== E_FETCH_RDY) begin $display("FAIL limit_return: got=%b exp=%b", outs, E_FETCH_RDY); bad++; end total++;
  endtask

  task automatic test_timeout();
    mem_ready = 1'b0;
    repeat (15) tick();
    if (outs !== E_FETCH) begin $display("FAIL timeout_pre: got=%b exp=%b", outs, E_FETCH); bad++; end total++;
    tick();
    if (outs !== E_ERR) begin $display("FAIL timeout_error: got=%b exp=%b", outs, E_ERR); bad++; end total++;
    resume = 1'b1; mem_ready = 1'b1;
    repeat (3) tick();
    if (outs !== E_ERR) begin $display("FAIL error_sticky: got=%b exp=%b", outs, E_ERR); bad++; end total++;
    resume = 1'b0;
    rst = 1'b1;
    #1;
    if (outs !== E_IDLE) begin $display("FAIL error_rst: got=%b exp=%b", outs, E_IDLE); bad++; end total++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    op_code = 4'b1001; mem_ready = 1'b1;
    tick();
    if (outs !== E_DECODE) begin $display("FAIL illegal_decode: got=%b exp=%b", outs, E_DECODE); bad++; end total++;
    tick();
    if (outs !== E_ERR) begin $display("FAIL illegal_opcode: got=%b exp=%b", outs, E_ERR); bad++; end total++;
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load_stall();
    test_store();
    test_cmp();
    test_blt();
    test_halt();
    test_rst_mid_access();
    test_timeout_boundary();
    test_timeout();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
